// File: rtl/fb_pkg.sv
// Shared framebuffer constants and the rectangle-writer FSM state type.
package fb_pkg;

  localparam int WIDTH_DEFAULT      = 640;
  localparam int HEIGHT_DEFAULT     = 480;
  localparam int ADDR_WIDTH_DEFAULT = 20;
  localparam int DATA_WIDTH_DEFAULT = 9;

  localparam int CMD_X_BITS = 10;
  localparam int CMD_Y_BITS = 9;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_FILL       = 2'd2,
    ST_DONE       = 2'd3
  } fb_state_e;

endpackage

// File: rtl/fb_rect_walker.sv
// Raster walker: column/row counters plus an incremental pixel address,
// stepping +1 along a row and reloading from row_base at each row end.
module fb_rect_walker
  import fb_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEFAULT,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic [CMD_X_BITS-1:0] x,
  input  logic [CMD_Y_BITS-1:0] y,
  input  logic [CMD_X_BITS-1:0] w,
  input  logic [CMD_Y_BITS-1:0] h,
  output logic                  last_pixel,
  output logic [ADDR_WIDTH-1:0] addr
);

  localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(WIDTH);

  logic [CMD_X_BITS-1:0] col_cnt;
  logic [CMD_Y_BITS-1:0] row_cnt;
  logic [CMD_X_BITS-1:0] col_last;
  logic [CMD_Y_BITS-1:0] row_last;
  logic [ADDR_WIDTH-1:0] x_off;
  logic [ADDR_WIDTH-1:0] row_base;
  logic [ADDR_WIDTH-1:0] addr_q;

  logic [ADDR_WIDTH-1:0] row_start;
  logic [ADDR_WIDTH-1:0] next_base;

  // Constant-coefficient product, evaluated once per command at load time;
  // the per-pixel path below only ever adds.
  assign row_start = ADDR_WIDTH'(y) * ROW_STRIDE;
  assign next_base = row_base + ROW_STRIDE;

  assign last_pixel = (col_cnt == col_last) && (row_cnt == row_last);
  assign addr       = addr_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_cnt  <= '0;
      row_cnt  <= '0;
      col_last <= '0;
      row_last <= '0;
      x_off    <= '0;
      row_base <= '0;
      addr_q   <= '0;
    end else if (load) begin
      col_cnt  <= '0;
      row_cnt  <= '0;
      col_last <= w - CMD_X_BITS'(1);
      row_last <= h - CMD_Y_BITS'(1);
      x_off    <= ADDR_WIDTH'(x);
      row_base <= row_start;
      addr_q   <= row_start + ADDR_WIDTH'(x);
    end else if (step) begin
      if (col_cnt == col_last) begin
        col_cnt  <= '0;
        row_cnt  <= row_cnt + CMD_Y_BITS'(1);
        row_base <= next_base;
        addr_q   <= next_base + x_off;
      end else begin
        col_cnt <= col_cnt + CMD_X_BITS'(1);
        addr_q  <= addr_q + ADDR_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/fb_rect_writer.sv
// Rectangle fill engine: accepts a clipped rectangle command and streams one
// palette-index write per cycle into pixel RAM in raster order.
module fb_rect_writer
  import fb_pkg::*;
#(
  parameter int WIDTH         = WIDTH_DEFAULT,
  parameter int HEIGHT        = HEIGHT_DEFAULT,
  parameter int ADDR_WIDTH    = ADDR_WIDTH_DEFAULT,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEFAULT,
  parameter bit SYNC_TO_FRAME = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [CMD_X_BITS-1:0] cmd_x,
  input  logic [CMD_Y_BITS-1:0] cmd_y,
  input  logic [CMD_X_BITS-1:0] cmd_w,
  input  logic [CMD_Y_BITS-1:0] cmd_h,
  input  logic [DATA_WIDTH-1:0] cmd_color,
  input  logic                  screen_end,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done
);

  localparam logic [CMD_X_BITS:0] WIDTH_X  = (CMD_X_BITS+1)'(WIDTH);
  localparam logic [CMD_Y_BITS:0] HEIGHT_Y = (CMD_Y_BITS+1)'(HEIGHT);

  fb_state_e state, state_next;

  logic [DATA_WIDTH-1:0] color_q;
  logic [CMD_X_BITS:0]   room_w;
  logic [CMD_Y_BITS:0]   room_h;
  logic [CMD_X_BITS-1:0] clip_w;
  logic [CMD_Y_BITS-1:0] clip_h;
  logic                  empty;
  logic                  accept;
  logic                  walk_load;
  logic                  walk_step;
  logic                  last_pixel;
  logic [ADDR_WIDTH-1:0] walk_addr;

  // room_* is only meaningful when the corner lies on screen; empty covers
  // the off-screen case before the clipped size is ever used.
  always_comb begin
    room_w = WIDTH_X - {1'b0, cmd_x};
    room_h = HEIGHT_Y - {1'b0, cmd_y};
    clip_w = ({1'b0, cmd_w} < room_w) ? cmd_w : room_w[CMD_X_BITS-1:0];
    clip_h = ({1'b0, cmd_h} < room_h) ? cmd_h : room_h[CMD_Y_BITS-1:0];
    empty  = ({1'b0, cmd_x} >= WIDTH_X) || ({1'b0, cmd_y} >= HEIGHT_Y) ||
             (clip_w == '0) || (clip_h == '0);
  end

  assign accept    = cmd_valid && (state == ST_IDLE);
  assign walk_load = accept && !empty;
  // Holding the walker on the final pixel keeps wr_addr inside the frame.
  assign walk_step = (state == ST_FILL) && !last_pixel;

  fb_rect_walker #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_walker (
    .clk        (clk),
    .reset      (reset),
    .load       (walk_load),
    .step       (walk_step),
    .x          (cmd_x),
    .y          (cmd_y),
    .w          (clip_w),
    .h          (clip_h),
    .last_pixel (last_pixel),
    .addr       (walk_addr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      color_q <= '0;
    end else begin
      state <= state_next;
      if (accept) color_q <= cmd_color;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    busy       = 1'b1;
    wr_en      = 1'b0;
    done       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          if (empty)              state_next = ST_DONE;
          else if (SYNC_TO_FRAME) state_next = ST_WAIT_FRAME;
          else                    state_next = ST_FILL;
        end
      end
      ST_WAIT_FRAME: begin
        if (screen_end) state_next = ST_FILL;
      end
      ST_FILL: begin
        wr_en = 1'b1;
        if (last_pixel) state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign wr_addr = walk_addr;
  assign wr_data = color_q;

endmodule

// File: tb/tb_fb_rect_writer.sv
// Directed bench: instance a free-runs (SYNC_TO_FRAME=0), instance b waits
// for screen_end (SYNC_TO_FRAME=1); expected values are hand-computed.
module tb_fb_rect_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_a, valid_b;
  logic [9:0]  cmd_x, cmd_w;
  logic [8:0]  cmd_y, cmd_h;
  logic [8:0]  cmd_color;
  logic        screen_end;

  logic        ready_a, wr_en_a, busy_a, done_a;
  logic [19:0] addr_a;
  logic [8:0]  data_a;
  logic        ready_b, wr_en_b, busy_b, done_b;
  logic [19:0] addr_b;
  logic [8:0]  data_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fb_rect_writer #(.SYNC_TO_FRAME(1'b0)) dut_a (
    .clk(clk), .reset(reset), .cmd_valid(valid_a), .cmd_ready(ready_a),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .screen_end(screen_end), .wr_en(wr_en_a),
    .wr_addr(addr_a), .wr_data(data_a), .busy(busy_a), .done(done_a)
  );

  fb_rect_writer #(.SYNC_TO_FRAME(1'b1)) dut_b (
    .clk(clk), .reset(reset), .cmd_valid(valid_b), .cmd_ready(ready_b),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .screen_end(screen_end), .wr_en(wr_en_b),
    .wr_addr(addr_b), .wr_data(data_b), .busy(busy_b), .done(done_b)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int x, input int y, input int w, input int h,
                         input int c);
    cmd_x     = 10'(x);
    cmd_y     = 9'(y);
    cmd_w     = 10'(w);
    cmd_h     = 9'(h);
    cmd_color = 9'(c);
  endtask

  task automatic send_a(input int x, input int y, input int w, input int h,
                        input int c);
    set_cmd(x, y, w, h, c);
    check("send_a_ready", 32'(ready_a), 1);
    valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
  endtask

  task automatic expect_write_a(input string tag, input int addr, input int data);
    check({tag, "_wr_en"}, 32'(wr_en_a), 1);
    check({tag, "_addr"}, 32'(addr_a), 32'(addr));
    check({tag, "_data"}, 32'(data_a), 32'(data));
    tick();
  endtask

  initial begin
    int t1_addr [6];
    t1_addr = '{1290, 1291, 1292, 1930, 1931, 1932};

    reset = 1'b1; valid_a = 1'b0; valid_b = 1'b0; screen_end = 1'b0;
    set_cmd(0, 0, 0, 0, 0);
    tick(); tick();

    check("rst_ready_a", 32'(ready_a), 1);
    check("rst_busy_a",  32'(busy_a),  0);
    check("rst_done_a",  32'(done_a),  0);
    check("rst_wr_en_a", 32'(wr_en_a), 0);
    check("rst_addr_a",  32'(addr_a),  0);
    check("rst_data_a",  32'(data_a),  0);
    check("rst_ready_b", 32'(ready_b), 1);
    check("rst_wr_en_b", 32'(wr_en_b), 0);
    reset = 1'b0;
    tick();

    // Test 1: 3x2 at (10,2)
    send_a(10, 2, 3, 2, 5);
    for (int i = 0; i < 6; i++) expect_write_a($sformatf("t1_w%0d", i), t1_addr[i], 5);
    check("t1_done",  32'(done_a),  1);
    check("t1_wr_off", 32'(wr_en_a), 0);
    tick();
    check("t1_done_end", 32'(done_a),  0);
    check("t1_ready",    32'(ready_a), 1);

    // Test 2: bottom-right corner clips to 2x1
    send_a(638, 479, 5, 4, 7);
    expect_write_a("t2_w0", 307198, 7);
    expect_write_a("t2_w1", 307199, 7);
    check("t2_done",   32'(done_a),  1);
    check("t2_wr_off", 32'(wr_en_a), 0);
    check("t2_addr_hold", 32'(addr_a), 307199);
    tick();

    // Test 3a: corner off-screen
    send_a(700, 0, 4, 4, 1);
    check("t3a_done",  32'(done_a),  1);
    check("t3a_wr",    32'(wr_en_a), 0);
    check("t3a_ready", 32'(ready_a), 0);
    tick();
    check("t3a_done_end", 32'(done_a),  0);
    check("t3a_ready_back", 32'(ready_a), 1);

    // Test 3b: zero width
    send_a(5, 5, 0, 3, 1);
    check("t3b_done",  32'(done_a),  1);
    check("t3b_wr",    32'(wr_en_a), 0);
    tick();
    check("t3b_ready_back", 32'(ready_a), 1);
    check("t3b_wr_idle",    32'(wr_en_a), 0);

    // Test 4: frame-synchronised fill on instance b
    set_cmd(1, 1, 2, 1, 3);
    valid_b = 1'b1;
    tick();
    valid_b = 1'b0;
    for (int i = 0; i < 49; i++) begin
      check($sformatf("t4_wait%0d_wr", i), 32'(wr_en_b), 0);
      check($sformatf("t4_wait%0d_busy", i), 32'(busy_b), 1);
      tick();
    end
    screen_end = 1'b1;
    check("t4_pulse_wr", 32'(wr_en_b), 0);
    tick();
    screen_end = 1'b0;
    check("t4_a_ignores_pulse", 32'(busy_a), 0);
    check("t4_w0_wr",   32'(wr_en_b), 1);
    check("t4_w0_addr", 32'(addr_b),  641);
    check("t4_w0_data", 32'(data_b),  3);
    tick();
    check("t4_w1_addr", 32'(addr_b), 642);
    tick();
    check("t4_done", 32'(done_b), 1);
    tick();
    check("t4_ready", 32'(ready_b), 1);

    // Test 5: reset during the 3rd write of a 4x4 fill
    send_a(0, 0, 4, 4, 9);
    expect_write_a("t5_w0", 0, 9);
    expect_write_a("t5_w1", 1, 9);
    check("t5_w2_wr",   32'(wr_en_a), 1);
    check("t5_w2_addr", 32'(addr_a),  2);
    reset = 1'b1;
    tick();
    check("t5_abort_wr",   32'(wr_en_a), 0);
    check("t5_abort_done", 32'(done_a),  0);
    check("t5_abort_data", 32'(data_a),  0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t5_post%0d_wr", i),    32'(wr_en_a), 0);
      check($sformatf("t5_post%0d_done", i),  32'(done_a),  0);
      check($sformatf("t5_post%0d_ready", i), 32'(ready_a), 1);
    end

    // Test 6: second command held during an active fill
    send_a(0, 0, 2, 2, 1);
    set_cmd(20, 10, 1, 2, 2);
    valid_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t6_busy%0d_ready", i), 32'(ready_a), 0);
      expect_write_a($sformatf("t6_a%0d", i), (i % 2) + 640 * (i / 2), 1);
    end
    check("t6_done1",       32'(done_a),  1);
    check("t6_done1_ready", 32'(ready_a), 0);
    tick();
    check("t6_idle_ready", 32'(ready_a), 1);
    check("t6_idle_wr",    32'(wr_en_a), 0);
    tick();
    valid_a = 1'b0;
    expect_write_a("t6_b0", 6420, 2);
    expect_write_a("t6_b1", 7060, 2);
    check("t6_done2", 32'(done_a), 1);
    tick();
    check("t6_done2_end", 32'(done_a),  0);
    check("t6_ready_end", 32'(ready_a), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
